// File: rtl/pwm_wave_synth.sv
// Multi-channel PWM waveform synthesiser: a shared 6-bit PWM counter and phase
// accumulator feed per-channel duty registers (sine/triangle/sawtooth/square).
module pwm_wave_synth #(
  parameter int CHANNELS = 2,
  parameter int ACC_BITS = 16
) (
  input  logic                  sysclk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [ACC_BITS-1:0]   freq_word,
  input  logic [6*CHANNELS-1:0] phase_off,
  output logic [CHANNELS-1:0]   pwm_out,
  output logic                  period_tick,
  output logic                  wrap_tick
);

  logic [5:0]          cnt_q, cnt_d;
  logic [ACC_BITS-1:0] acc_q, acc_d;
  logic                wrap_q, wrap_d;
  logic [ACC_BITS:0]   acc_sum;
  logic                boundary;

  // Quarter-symmetric sine table: first half of the cycle, 0..64.
  function automatic logic [6:0] sine_lut(input logic [4:0] i);
    logic [6:0] v;
    case (i)
      5'd0:  v = 7'd0;   5'd1:  v = 7'd0;   5'd2:  v = 7'd1;   5'd3:  v = 7'd1;
      5'd4:  v = 7'd3;   5'd5:  v = 7'd4;   5'd6:  v = 7'd6;   5'd7:  v = 7'd8;
      5'd8:  v = 7'd10;  5'd9:  v = 7'd12;  5'd10: v = 7'd15;  5'd11: v = 7'd18;
      5'd12: v = 7'd21;  5'd13: v = 7'd24;  5'd14: v = 7'd27;  5'd15: v = 7'd30;
      5'd16: v = 7'd34;  5'd17: v = 7'd37;  5'd18: v = 7'd40;  5'd19: v = 7'd43;
      5'd20: v = 7'd46;  5'd21: v = 7'd49;  5'd22: v = 7'd52;  5'd23: v = 7'd54;
      5'd24: v = 7'd56;  5'd25: v = 7'd58;  5'd26: v = 7'd60;  5'd27: v = 7'd61;
      5'd28: v = 7'd63;  5'd29: v = 7'd63;  5'd30: v = 7'd64;  default: v = 7'd64;
    endcase
    return v;
  endfunction

  function automatic logic [6:0] wave(input logic [1:0] m, input logic [5:0] i);
    logic [6:0] v;
    case (m)
      // Second half mirrors the table: 63-i equals ~i[4:0] when i[5] is set.
      2'd0:    v = i[5] ? sine_lut(~i[4:0]) : sine_lut(i[4:0]);
      2'd1:    v = i[5] ? (7'd0 - {i, 1'b0}) : {i, 1'b0};
      2'd2:    v = {1'b0, i};
      default: v = i[5] ? 7'd0 : 7'd64;
    endcase
    return v;
  endfunction

  assign boundary    = (cnt_q == 6'd63);
  assign period_tick = boundary;
  assign wrap_tick   = wrap_q;
  assign acc_sum     = {1'b0, acc_q} + {1'b0, freq_word};

  always_comb begin
    cnt_d  = cnt_q + 6'd1;
    acc_d  = acc_q;
    wrap_d = wrap_q;
    if (boundary) begin
      acc_d  = en ? acc_sum[ACC_BITS-1:0] : '0;
      wrap_d = en & acc_sum[ACC_BITS];
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      wrap_q <= wrap_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [5:0] idx;
      logic [6:0] duty_q, duty_d;

      // Index uses the accumulator value from before this boundary's update.
      assign idx = acc_q[ACC_BITS-1 -: 6] + phase_off[6*gi +: 6];

      always_comb begin
        duty_d = duty_q;
        if (boundary) begin
          duty_d = en ? wave(mode, idx) : 7'd0;
        end
      end

      always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
          duty_q <= 7'd0;
        end else begin
          duty_q <= duty_d;
        end
      end

      // Duty 64 exceeds every counter value, so the output stays high across the wrap.
      assign pwm_out[gi] = ({1'b0, cnt_q} < duty_q);
    end
  endgenerate

endmodule

// File: tb/tb_pwm_wave_synth.sv
// Self-checking bench for pwm_wave_synth: behavioural reference model compared
// every cycle, plus directed scenarios with hand-computed duty/wrap expectations.
module tb_pwm_wave_synth;
  localparam int CH = 2;
  localparam int AB = 16;

  logic          sysclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [AB-1:0] freq_word = '0;
  logic [6*CH-1:0] phase_off = '0;
  logic [CH-1:0] pwm_out;
  logic          period_tick;
  logic          wrap_tick;

  int checks = 0;
  int errors = 0;

  pwm_wave_synth #(.CHANNELS(CH), .ACC_BITS(AB)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .en(en), .mode(mode),
    .freq_word(freq_word), .phase_off(phase_off),
    .pwm_out(pwm_out), .period_tick(period_tick), .wrap_tick(wrap_tick)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int sine_tab [32] = '{0,0,1,1,3,4,6,8,10,12,15,18,21,24,27,30,
                        34,37,40,43,46,49,52,54,56,58,60,61,63,63,64,64};

  function automatic int wave_ref(input int m, input int i);
    case (m)
      0:       return (i < 32) ? sine_tab[i] : sine_tab[63-i];
      1:       return (i < 32) ? 2*i : 128 - 2*i;
      2:       return i;
      default: return (i < 32) ? 64 : 0;
    endcase
  endfunction

  int m_cnt = 0;
  int m_acc = 0;
  int m_wrap = 0;
  int m_duty [CH];

  always @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  <= 0;
      m_acc  <= 0;
      m_wrap <= 0;
      for (int k = 0; k < CH; k++) m_duty[k] <= 0;
    end else begin
      if (m_cnt == 63) begin
        for (int k = 0; k < CH; k++)
          m_duty[k] <= en ? wave_ref(int'(mode),
                         ((m_acc >> (AB-6)) + int'(phase_off[6*k +: 6])) % 64) : 0;
        m_wrap <= (en && (m_acc + int'(freq_word) >= (1 << AB))) ? 1 : 0;
        m_acc  <= en ? (m_acc + int'(freq_word)) % (1 << AB) : 0;
      end
      m_cnt <= (m_cnt + 1) % 64;
    end
  end

  always @(negedge sysclk) begin
    for (int k = 0; k < CH; k++)
      chk("pwm_out_vs_model", pwm_out[k], (m_cnt < m_duty[k]) ? 1 : 0);
    chk("period_tick_vs_model", period_tick, (m_cnt == 63) ? 1 : 0);
    chk("wrap_tick_vs_model", wrap_tick, m_wrap);
  end

  // ---------------- helpers ----------------
  task automatic sync_tick();
    int g = 0;
    while (!period_tick && g < 200) begin
      @(negedge sysclk);
      g++;
    end
    chk("period_tick_seen", period_tick, 1);
  endtask

  // Counts high cycles of each channel over the next full period.
  task automatic measure(output int h0, output int h1, output int w);
    sync_tick();
    h0 = 0; h1 = 0; w = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge sysclk);
      if (c == 0) w = wrap_tick;
      h0 += pwm_out[0];
      h1 += pwm_out[1];
    end
  endtask

  task automatic wait_cnt(input int n);
    sync_tick();
    repeat (n + 1) @(negedge sysclk);
  endtask

  task automatic restart();
    @(negedge sysclk);
    rst_n = 1'b0;
    @(negedge sysclk);
    rst_n = 1'b1;
  endtask

  int d0 [66];
  int d1 [66];
  int wr [66];
  int exp_sine [8] = '{0,0,1,1,3,4,6,8};
  int n, h0, h1, w;

  initial begin
    // Reset held with en high
    en = 1'b1; mode = 2'd0; freq_word = 16'h0400; phase_off = '0;
    repeat (5) @(negedge sysclk);
    chk("reset_pwm_out", pwm_out, 0);
    chk("reset_period_tick", period_tick, 0);
    chk("reset_wrap_tick", wrap_tick, 0);
    rst_n = 1'b1;
    n = 0;
    while (!period_tick && n < 200) begin
      @(negedge sysclk);
      n++;
    end
    // cnt reads 63 after 63 edges; the boundary is the 64th clock after release.
    chk("edges_to_first_period_tick", n, 63);

    // Sine sweep, freq_word 0x0400: one index step per period
    for (int b = 1; b <= 65; b++) measure(d0[b], d1[b], wr[b]);
    for (int b = 1; b <= 8; b++) chk("sine_duty", d0[b], exp_sine[b-1]);
    for (int b = 31; b <= 34; b++) chk("sine_peak_full_high", d0[b], 64);
    chk("sine_wrap_before", wr[63], 0);
    chk("sine_wrap_at_64", wr[64], 1);
    chk("sine_wrap_after", wr[65], 0);

    // Mid-period mode change only lands at the next boundary (idx 1 -> square 64)
    wait_cnt(20);
    mode = 2'd3;
    measure(h0, h1, w);
    chk("mode_change_next_period", h0, 64);

    // Square with complementary phase offsets
    mode = 2'd3; phase_off = {6'd32, 6'd0}; freq_word = 16'h0400; en = 1'b1;
    restart();
    for (int b = 1; b <= 64; b++) measure(d0[b], d1[b], wr[b]);
    chk("square_b1_ch0", d0[1], 64);  chk("square_b1_ch1", d1[1], 0);
    chk("square_b32_ch0", d0[32], 64); chk("square_b32_ch1", d1[32], 0);
    chk("square_b33_ch0", d0[33], 0);  chk("square_b33_ch1", d1[33], 64);
    chk("square_b64_ch0", d0[64], 0);  chk("square_b64_ch1", d1[64], 64);

    // Asynchronous reset mid-period
    wait_cnt(20);
    chk("pre_reset_pwm_out", pwm_out, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_pwm_out", pwm_out, 0);
    chk("async_reset_period_tick", period_tick, 0);

    // Sawtooth, half-cycle steps
    mode = 2'd2; freq_word = 16'h8000; phase_off = '0; en = 1'b1;
    @(negedge sysclk);
    rst_n = 1'b1;
    for (int b = 1; b <= 4; b++) measure(d0[b], d1[b], wr[b]);
    chk("saw_b1", d0[1], 0);  chk("saw_b2", d0[2], 32);
    chk("saw_b3", d0[3], 0);  chk("saw_b4", d0[4], 32);
    chk("saw_w1", wr[1], 0);  chk("saw_w2", wr[2], 1);
    chk("saw_w3", wr[3], 0);  chk("saw_w4", wr[4], 1);

    // Enable gating, then re-enable into triangle with offset 16
    wait_cnt(10);
    en = 1'b0;
    measure(h0, h1, w);
    chk("disabled_duty", h0, 0);
    chk("disabled_wrap", w, 0);
    measure(h0, h1, w);
    chk("disabled_duty_2", h0, 0);
    en = 1'b1; mode = 2'd1; freq_word = 16'h0400; phase_off = {6'd0, 6'd16};
    measure(h0, h1, w);
    chk("model_tri_first", m_duty[0], 32);
    chk("tri_first_ch0", h0, 32); chk("tri_first_ch1", h1, 0);
    measure(h0, h1, w);
    chk("tri_second_ch0", h0, 34); chk("tri_second_ch1", h1, 2);
    measure(h0, h1, w);
    chk("tri_third_ch0", h0, 36);

    // Randomized traffic, checked every cycle against the model
    for (int it = 0; it < 60; it++) begin
      repeat ($urandom_range(1, 150)) @(negedge sysclk);
      case ($urandom_range(0, 9))
        0, 1:    mode = 2'($urandom_range(0, 3));
        2, 3:    freq_word = 16'($urandom_range(0, 65535));
        4, 5:    phase_off = 12'($urandom_range(0, 4095));
        6, 7:    en = ($urandom_range(0, 3) != 0);
        8:       begin mode = 2'($urandom_range(0, 3)); en = 1'b1; end
        default: begin
          #2 rst_n = 1'b0;
          #1 chk("rand_async_reset_pwm", pwm_out, 0);
          repeat ($urandom_range(1, 3)) @(negedge sysclk);
          rst_n = 1'b1;
        end
      endcase
    end
    repeat (130) @(negedge sysclk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
